// File: rtl/pll_lock_sequencer_pkg.sv
// Shared types and widths for the PLL lock sequencer.
package pll_seq_pkg;

  // Sequencer states; the encoding is exported on O_state for debug.
  typedef enum logic [2:0] {
    RESET_PLL = 3'd0,
    WAIT_LOCK = 3'd1,
    STABLE    = 3'd2,
    RUN       = 3'd3,
    FAIL      = 3'd4
  } pll_state_t;

  localparam int LOSS_W  = 8;
  localparam int RETRY_W = 2;

  // Counter width for a terminal count of n; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pll_lock_sequencer_sync_2ff.sv
// Two-flop synchroniser for asynchronous level inputs; resets to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // First flop may go metastable; second flop gives it a cycle to settle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_sequencer.sv
// Brings the HDMI PLL from power-up to a qualified, stable lock, then
// releases the downstream reset. Retries on lock timeout, recovers on
// lock loss, and parks in FAIL after too many timed-out attempts.
module pll_lock_sequencer
  import pll_seq_pkg::*;
#(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 27000,
  parameter int STABLE_CYCLES       = 2700,
  parameter int MAX_RETRIES         = 3
) (
  input  logic               I_clk,
  input  logic               I_rst_n,
  input  logic               I_pll_lock,
  input  logic               I_restart,
  output logic               O_pll_reset,
  output logic               O_rst_n,
  output logic               O_locked,
  output logic               O_fail,
  output logic [RETRY_W-1:0] O_retry_cnt,
  output logic [LOSS_W-1:0]  O_loss_cnt,
  output logic [2:0]         O_state
);

  localparam int PW = cnt_w(RST_PULSE_CYCLES);
  localparam int TW = cnt_w(LOCK_TIMEOUT_CYCLES);
  localparam int SW = cnt_w(STABLE_CYCLES);

  localparam logic [PW-1:0]      PULSE_LAST = PW'(RST_PULSE_CYCLES - 1);
  localparam logic [TW-1:0]      TMO_LAST   = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [SW-1:0]      STAB_LAST  = SW'(STABLE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRIES);

  pll_state_t         state, state_nxt;
  logic [PW-1:0]      pulse_cnt, pulse_nxt;
  logic [TW-1:0]      tmo_cnt, tmo_nxt;
  logic [SW-1:0]      stab_cnt, stab_nxt;
  logic [RETRY_W-1:0] retry_nxt;
  logic [LOSS_W-1:0]  loss_nxt;
  logic               lock_s;
  logic               run_go;
  logic               tmo_hit;

  sync_2ff #(.WIDTH(1)) u_lock_sync (
    .clk   (I_clk),
    .rst_n (I_rst_n),
    .d     (I_pll_lock),
    .q     (lock_s)
  );

  // Qualification complete this cycle; beats a coincident timeout.
  assign run_go  = (state == STABLE) && lock_s && (stab_cnt == STAB_LAST);
  assign tmo_hit = (state == WAIT_LOCK || state == STABLE) && (tmo_cnt == TMO_LAST);

  assign O_state = state;

  // Next-state and next-counter decode; restart overrides everything except loss counting.
  always_comb begin
    state_nxt = state;
    pulse_nxt = pulse_cnt;
    tmo_nxt   = tmo_cnt;
    stab_nxt  = stab_cnt;
    retry_nxt = O_retry_cnt;
    loss_nxt  = O_loss_cnt;
    unique case (state)
      RESET_PLL: begin
        if (pulse_cnt == PULSE_LAST) begin
          state_nxt = WAIT_LOCK;
          pulse_nxt = '0;
          tmo_nxt   = '0;
        end else begin
          pulse_nxt = pulse_cnt + 1'b1;
        end
      end
      WAIT_LOCK, STABLE: begin
        // The timeout window spans both states and is only cleared on WAIT_LOCK entry.
        tmo_nxt = tmo_cnt + 1'b1;
        if (run_go) begin
          state_nxt = RUN;
          retry_nxt = '0;
        end else if (tmo_hit) begin
          retry_nxt = O_retry_cnt + 1'b1;
          if (retry_nxt == RETRY_MAX) begin
            state_nxt = FAIL;
          end else begin
            state_nxt = RESET_PLL;
            pulse_nxt = '0;
          end
        end else if (state == WAIT_LOCK) begin
          if (lock_s) begin
            state_nxt = STABLE;
            stab_nxt  = '0;
          end
        end else if (!lock_s) begin
          // Glitch: drop back and requalify from scratch on the next lock.
          state_nxt = WAIT_LOCK;
        end else begin
          stab_nxt = stab_cnt + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_nxt = RESET_PLL;
          pulse_nxt = '0;
          retry_nxt = '0;
          if (O_loss_cnt != '1) loss_nxt = O_loss_cnt + 1'b1;
        end
      end
      FAIL: begin
        state_nxt = FAIL;
      end
      default: begin
        state_nxt = RESET_PLL;
        pulse_nxt = '0;
      end
    endcase
    if (I_restart) begin
      state_nxt = RESET_PLL;
      pulse_nxt = '0;
      retry_nxt = '0;
    end
  end

  // State, counters and outputs; outputs decode next-state so they move with the state.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      state       <= RESET_PLL;
      pulse_cnt   <= '0;
      tmo_cnt     <= '0;
      stab_cnt    <= '0;
      O_retry_cnt <= '0;
      O_loss_cnt  <= '0;
      O_pll_reset <= 1'b1;
      O_rst_n     <= 1'b0;
      O_locked    <= 1'b0;
      O_fail      <= 1'b0;
    end else begin
      state       <= state_nxt;
      pulse_cnt   <= pulse_nxt;
      tmo_cnt     <= tmo_nxt;
      stab_cnt    <= stab_nxt;
      O_retry_cnt <= retry_nxt;
      O_loss_cnt  <= loss_nxt;
      O_pll_reset <= (state_nxt == RESET_PLL) || (state_nxt == FAIL);
      O_rst_n     <= (state_nxt == RUN);
      O_locked    <= (state_nxt == RUN);
      O_fail      <= (state_nxt == FAIL);
    end
  end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Bench for pll_lock_sequencer: directed scenarios plus randomized lock
// traffic, every cycle compared against a phase/age reference model.
module tb_pll_lock_sequencer;

  localparam int RP = 4;
  localparam int TO = 64;
  localparam int ST = 8;
  localparam int MR = 2;

  localparam int PH_PULSE = 0;
  localparam int PH_ATT   = 1;
  localparam int PH_UP    = 2;
  localparam int PH_DEAD  = 3;

  logic       I_clk = 1'b0;
  logic       I_rst_n = 1'b0;
  logic       I_pll_lock = 1'b0;
  logic       I_restart = 1'b0;
  logic       O_pll_reset, O_rst_n, O_locked, O_fail;
  logic [1:0] O_retry_cnt;
  logic [7:0] O_loss_cnt;
  logic [2:0] O_state;

  pll_lock_sequencer #(
    .RST_PULSE_CYCLES    (RP),
    .LOCK_TIMEOUT_CYCLES (TO),
    .STABLE_CYCLES       (ST),
    .MAX_RETRIES         (MR)
  ) dut (
    .I_clk       (I_clk),
    .I_rst_n     (I_rst_n),
    .I_pll_lock  (I_pll_lock),
    .I_restart   (I_restart),
    .O_pll_reset (O_pll_reset),
    .O_rst_n     (O_rst_n),
    .O_locked    (O_locked),
    .O_fail      (O_fail),
    .O_retry_cnt (O_retry_cnt),
    .O_loss_cnt  (O_loss_cnt),
    .O_state     (O_state)
  );

  always #5 I_clk = ~I_clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Reference model: phase plus elapsed counts within the phase.
  int   ph, pulse_done, age, hi, retries, losses;
  logic d1, d2;

  task automatic m_reset();
    ph = PH_PULSE; pulse_done = 0; age = 0; hi = 0;
    retries = 0; losses = 0; d1 = 1'b0; d2 = 1'b0;
  endtask

  task automatic m_edge(input logic lk, input logic rs);
    logic ls;
    ls = d2; d2 = d1; d1 = lk;
    if (rs) begin
      if (ph == PH_UP && !ls && losses < 255) losses++;
      ph = PH_PULSE; pulse_done = 0; retries = 0;
      return;
    end
    case (ph)
      PH_PULSE: begin
        pulse_done++;
        if (pulse_done == RP) begin ph = PH_ATT; age = 0; hi = 0; end
      end
      PH_ATT: begin
        age++;
        hi = ls ? hi + 1 : 0;
        // one edge to notice lock, then ST more consecutive lock edges
        if (hi == ST + 1) begin
          ph = PH_UP; retries = 0;
        end else if (age == TO) begin
          retries++;
          if (retries == MR) ph = PH_DEAD;
          else begin ph = PH_PULSE; pulse_done = 0; end
        end
      end
      PH_UP: begin
        if (!ls) begin
          if (losses < 255) losses++;
          retries = 0; ph = PH_PULSE; pulse_done = 0;
        end
      end
      default: ;
    endcase
  endtask

  function automatic int m_code();
    case (ph)
      PH_PULSE: return 0;
      PH_ATT:   return (hi > 0) ? 2 : 1;
      PH_UP:    return 3;
      default:  return 4;
    endcase
  endfunction

  task automatic check_all();
    chk("pll_reset", O_pll_reset, (ph == PH_PULSE || ph == PH_DEAD));
    chk("rst_n",     O_rst_n,     (ph == PH_UP));
    chk("locked",    O_locked,    (ph == PH_UP));
    chk("fail",      O_fail,      (ph == PH_DEAD));
    chk("retry_cnt", O_retry_cnt, retries);
    chk("loss_cnt",  O_loss_cnt,  losses);
    chk("state",     O_state,     m_code());
  endtask

  // One clock: inputs set before the edge feed the model; outputs checked on the falling edge.
  task automatic step();
    logic lk, rs;
    lk = I_pll_lock; rs = I_restart;
    @(posedge I_clk);
    m_edge(lk, rs);
    @(negedge I_clk);
    check_all();
  endtask

  task automatic wait_state(input string tag, input logic [2:0] code, input int budget);
    int k;
    k = 0;
    while (O_state != code && k < budget) begin step(); k++; end
    chk(tag, O_state, code);
  endtask

  task automatic wait_age(input int a, input int budget);
    int k;
    k = 0;
    while (!(ph == PH_ATT && age == a) && k < budget) begin step(); k++; end
  endtask

  task automatic async_rst();
    #2 I_rst_n = 1'b0;
    m_reset();
    #1 check_all();
    chk("arst_loss", O_loss_cnt, 0);
    chk("arst_state", O_state, 0);
    @(negedge I_clk);
    I_rst_n = 1'b1;
  endtask

  initial begin
    int n, m, pulses;
    m_reset();
    repeat (3) @(negedge I_clk);
    check_all();
    I_rst_n = 1'b1;

    // Nominal: lock 10 cycles after the pulse ends; the first step holds the sampling edge.
    wait_state("nom_wait", 3'd1, 20);
    repeat (10) step();
    I_pll_lock = 1'b1;
    n = 0;
    do begin step(); n++; end while (O_state != 3'd2 && n < 20);
    chk("nom_stable_lat", n, 3);
    m = 0;
    do begin step(); m++; end while (!O_locked && m < 20);
    chk("nom_run_lat", m, 8);
    chk("nom_retry", O_retry_cnt, 0);

    // Glitch during qualification: no new PLL reset pulse, eventually RUN.
    I_restart = 1'b1; I_pll_lock = 1'b0;
    step();
    I_restart = 1'b0;
    wait_state("gl_wait", 3'd1, 20);
    pulses = 0;
    I_pll_lock = 1'b1;
    repeat (5) begin step(); pulses += O_pll_reset; end
    I_pll_lock = 1'b0;
    step(); pulses += O_pll_reset;
    I_pll_lock = 1'b1;
    n = 0;
    while (O_state != 3'd3 && n < 40) begin step(); pulses += O_pll_reset; n++; end
    chk("gl_run", O_state, 3);
    chk("gl_nopulse", pulses, 0);

    // Lock never returns: two timeouts then FAIL; restart gives a fresh pulse.
    I_pll_lock = 1'b0;
    wait_state("tmo_fail", 3'd4, 300);
    chk("tmo_fail_flag", O_fail, 1);
    chk("tmo_fail_rst", O_pll_reset, 1);
    repeat (5) step();
    chk("tmo_fail_hold", O_fail, 1);
    I_restart = 1'b1;
    step();
    I_restart = 1'b0;
    chk("rs_fail", O_fail, 0);
    chk("rs_retry", O_retry_cnt, 0);
    n = 1;
    while (O_pll_reset && n < 10) begin step(); n++; end
    chk("rs_pulse_len", n - 1, RP);

    // Lock loss in RUN, repeated until the loss counter saturates.
    I_pll_lock = 1'b1;
    wait_state("loss_pre", 3'd3, 40);
    I_pll_lock = 1'b0;
    n = 0;
    do begin step(); n++; end while (O_rst_n && n < 10);
    chk("loss_lat", n, 3);
    I_pll_lock = 1'b1;
    wait_state("loss_relock", 3'd3, 60);
    repeat (259) begin
      I_pll_lock = 1'b0;
      repeat ($urandom_range(1, 5)) step();
      wait_state("loss_drop", 3'd0, 10);
      I_pll_lock = 1'b1;
      wait_state("loss_relock", 3'd3, 60);
    end
    chk("loss_sat", O_loss_cnt, 255);

    // Asynchronous reset in the middle of STABLE.
    I_pll_lock = 1'b0;
    wait_state("ar_drop", 3'd0, 10);
    wait_state("ar_wait", 3'd1, 20);
    I_pll_lock = 1'b1;
    wait_state("ar_stable", 3'd2, 20);
    repeat (2) step();
    I_pll_lock = 1'b0;
    async_rst();

    // Qualification finishes on the very last timeout cycle: RUN wins.
    wait_age(53, 200);
    chk("coll_pre", O_state, 1);
    I_pll_lock = 1'b1;
    wait_state("coll_run", 3'd3, 40);
    chk("coll_retry", O_retry_cnt, 0);

    // One cycle later the timeout wins instead.
    I_pll_lock = 1'b0;
    wait_state("late_drop", 3'd0, 10);
    wait_age(54, 200);
    I_pll_lock = 1'b1;
    wait_state("late_tmo", 3'd0, 40);
    chk("late_retry", O_retry_cnt, 1);
    wait_state("late_run", 3'd3, 60);
    chk("late_clr", O_retry_cnt, 0);

    // Random lock segments with sporadic restarts and resets.
    repeat (300) begin
      I_pll_lock = ($urandom_range(0, 3) != 0);
      repeat ($urandom_range(1, 40)) begin
        I_restart = ($urandom_range(0, 99) == 0);
        step();
      end
      I_restart = 1'b0;
      if ($urandom_range(0, 49) == 0) async_rst();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
